// File: rtl/risc16_pipe_core.sv
// RiSC-16 five-stage in-order pipeline (IF/ID/EX/MEM/WB) with full EX forwarding,
// single-cycle load-use stall and EX-resolved branches (predict not-taken).

module risc16_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [2:0]  i_raddr_a,
    input  logic [2:0]  i_raddr_b,
    input  logic [2:0]  i_raddr_c,
    output logic [15:0] o_rdata_a,
    output logic [15:0] o_rdata_b,
    output logic [15:0] o_rdata_c
);
    logic [15:0] r_memory [0:7];

    // r0 is hardwired to zero; a same-cycle WB write is visible to the reader
    function automatic logic [15:0] read_port(input logic [2:0] addr, input logic we,
                                              input logic [2:0] waddr, input logic [15:0] wdata,
                                              input logic [15:0] stored);
        logic [15:0] val;
        if (addr == 3'd0) begin
            val = 16'd0;
        end else if (we && (addr == waddr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign o_rdata_a = read_port(i_raddr_a, i_we, i_waddr, i_wdata, r_memory[i_raddr_a]);
    assign o_rdata_b = read_port(i_raddr_b, i_we, i_waddr, i_wdata, r_memory[i_raddr_b]);
    assign o_rdata_c = read_port(i_raddr_c, i_we, i_waddr, i_wdata, r_memory[i_raddr_c]);

    // Register storage; writes to r0 are dropped
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 8; i++) begin
                r_memory[i] <= 16'd0;
            end
        end else if (i_we && (i_waddr != 3'd0)) begin
            r_memory[i_waddr] <= i_wdata;
        end
    end
endmodule

module risc16_pipe_core #(
    parameter logic [15:0] p_RESET_PC = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_inst,
    output logic [15:0] o_pc,
    input  logic [15:0] i_mem_rd_data,
    output logic [15:0] o_mem_wr_data,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_wr_en
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    function automatic logic writes_reg(input logic [2:0] op);
        return (op != OP_SW) && (op != OP_BEQ);
    endfunction

    // MEM (ALU result) wins over WB; r0 never forwarded
    function automatic logic [15:0] fwd(input logic [2:0] src, input logic [15:0] rf_val,
                                        input logic m_ok, input logic [2:0] m_dst, input logic [15:0] m_val,
                                        input logic w_ok, input logic [2:0] w_dst, input logic [15:0] w_val);
        logic [15:0] val;
        if (src == 3'd0) begin
            val = rf_val;
        end else if (m_ok && (m_dst == src)) begin
            val = m_val;
        end else if (w_ok && (w_dst == src)) begin
            val = w_val;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    logic [15:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d, id_load_s;
    logic [15:0] id_inst_q, id_pc_q;
    logic        ex_valid_q, ex_valid_d;
    logic [15:0] ex_inst_q, ex_pc_q, ex_a_q, ex_b_q, ex_c_q;
    logic        mem_valid_q, mem_we_q;
    logic [2:0]  mem_op_q, mem_dst_q;
    logic [15:0] mem_result_q, mem_store_q, mem_npc_q;
    logic        r_valid_wb;
    logic [2:0]  wb_op_q, wb_dst_q;
    logic [15:0] wb_result_q, r_pc_wb;

    logic [2:0]  id_op_s, id_ra_s, id_rb_s, id_rc_s;
    logic [15:0] rf_a_s, rf_b_s, rf_c_s;
    logic        id_uses_ra_s, id_uses_rb_s, id_uses_rc_s, load_use_s;
    logic [2:0]  ex_op_s, ex_ra_s, ex_rb_s, ex_rc_s;
    logic [15:0] ex_simm_s, a_s, b_s, c_s, ex_result_s, ex_seq_s, ex_target_s, ex_npc_s;
    logic        redirect_s, mem_fwd_ok_s, wb_fwd_ok_s, wb_we_s;

    assign id_op_s = id_inst_q[15:13];
    assign id_ra_s = id_inst_q[12:10];
    assign id_rb_s = id_inst_q[9:7];
    assign id_rc_s = id_inst_q[2:0];
    assign id_uses_ra_s = (id_op_s == OP_SW) || (id_op_s == OP_BEQ);
    assign id_uses_rb_s = (id_op_s != OP_LUI);
    assign id_uses_rc_s = (id_op_s == OP_ADD) || (id_op_s == OP_NAND);
    assign load_use_s = id_valid_q && ex_valid_q && (ex_op_s == OP_LW) &&
                        ((id_uses_ra_s && (id_ra_s == ex_ra_s)) ||
                         (id_uses_rb_s && (id_rb_s == ex_ra_s)) ||
                         (id_uses_rc_s && (id_rc_s == ex_ra_s)));

    assign wb_we_s = r_valid_wb && writes_reg(wb_op_q);

    risc16_regfile regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (wb_we_s),
        .i_waddr   (wb_dst_q),
        .i_wdata   (wb_result_q),
        .i_raddr_a (id_ra_s),
        .i_raddr_b (id_rb_s),
        .i_raddr_c (id_rc_s),
        .o_rdata_a (rf_a_s),
        .o_rdata_b (rf_b_s),
        .o_rdata_c (rf_c_s)
    );

    assign ex_op_s   = ex_inst_q[15:13];
    assign ex_ra_s   = ex_inst_q[12:10];
    assign ex_rb_s   = ex_inst_q[9:7];
    assign ex_rc_s   = ex_inst_q[2:0];
    assign ex_simm_s = {{9{ex_inst_q[6]}}, ex_inst_q[6:0]};
    assign ex_seq_s  = ex_pc_q + 16'd1;

    // A load in MEM has no data yet; the load-use stall covers that case
    assign mem_fwd_ok_s = mem_valid_q && writes_reg(mem_op_q) && (mem_op_q != OP_LW);
    assign wb_fwd_ok_s  = wb_we_s;
    assign a_s = fwd(ex_ra_s, ex_a_q, mem_fwd_ok_s, mem_dst_q, mem_result_q, wb_fwd_ok_s, wb_dst_q, wb_result_q);
    assign b_s = fwd(ex_rb_s, ex_b_q, mem_fwd_ok_s, mem_dst_q, mem_result_q, wb_fwd_ok_s, wb_dst_q, wb_result_q);
    assign c_s = fwd(ex_rc_s, ex_c_q, mem_fwd_ok_s, mem_dst_q, mem_result_q, wb_fwd_ok_s, wb_dst_q, wb_result_q);

    // EX datapath: ALU result doubles as the data address for SW/LW
    always_comb begin
        ex_result_s = 16'd0;
        case (ex_op_s)
            OP_ADD:  ex_result_s = b_s + c_s;
            OP_ADDI: ex_result_s = b_s + ex_simm_s;
            OP_NAND: ex_result_s = ~(b_s & c_s);
            OP_LUI:  ex_result_s = {ex_inst_q[9:0], 6'd0};
            OP_SW:   ex_result_s = b_s + ex_simm_s;
            OP_LW:   ex_result_s = b_s + ex_simm_s;
            OP_JALR: ex_result_s = ex_seq_s;
            default: ex_result_s = 16'd0;
        endcase
    end

    assign redirect_s  = ex_valid_q && (((ex_op_s == OP_BEQ) && (a_s == b_s)) || (ex_op_s == OP_JALR));
    assign ex_target_s = (ex_op_s == OP_JALR) ? b_s : (ex_seq_s + ex_simm_s);
    assign ex_npc_s    = redirect_s ? ex_target_s : ex_seq_s;

    // Front-end control: redirect flushes IF/ID, load-use freezes them
    always_comb begin
        pc_d       = pc_q + 16'd1;
        id_valid_d = 1'b1;
        id_load_s  = 1'b1;
        ex_valid_d = id_valid_q;
        if (redirect_s) begin
            pc_d       = ex_target_s;
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
        end else if (load_use_s) begin
            pc_d       = pc_q;
            id_valid_d = id_valid_q;
            id_load_s  = 1'b0;
            ex_valid_d = 1'b0;
        end else begin
            pc_d       = pc_q + 16'd1;
            id_valid_d = 1'b1;
            id_load_s  = 1'b1;
            ex_valid_d = id_valid_q;
        end
    end

    // Pipeline registers for all stages
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pc_q         <= p_RESET_PC;
            id_valid_q   <= 1'b0;
            id_inst_q    <= 16'd0;
            id_pc_q      <= 16'd0;
            ex_valid_q   <= 1'b0;
            ex_inst_q    <= 16'd0;
            ex_pc_q      <= 16'd0;
            ex_a_q       <= 16'd0;
            ex_b_q       <= 16'd0;
            ex_c_q       <= 16'd0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_op_q     <= 3'd0;
            mem_dst_q    <= 3'd0;
            mem_result_q <= 16'd0;
            mem_store_q  <= 16'd0;
            mem_npc_q    <= 16'd0;
            r_valid_wb   <= 1'b0;
            wb_op_q      <= 3'd0;
            wb_dst_q     <= 3'd0;
            wb_result_q  <= 16'd0;
            r_pc_wb      <= 16'd0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            if (id_load_s) begin
                id_inst_q <= i_inst;
                id_pc_q   <= pc_q;
            end
            ex_valid_q   <= ex_valid_d;
            ex_inst_q    <= id_inst_q;
            ex_pc_q      <= id_pc_q;
            ex_a_q       <= rf_a_s;
            ex_b_q       <= rf_b_s;
            ex_c_q       <= rf_c_s;
            mem_valid_q  <= ex_valid_q;
            mem_we_q     <= ex_valid_q && (ex_op_s == OP_SW);
            mem_op_q     <= ex_op_s;
            mem_dst_q    <= ex_ra_s;
            mem_result_q <= ex_result_s;
            mem_store_q  <= a_s;
            mem_npc_q    <= ex_npc_s;
            r_valid_wb   <= mem_valid_q;
            wb_op_q      <= mem_op_q;
            wb_dst_q     <= mem_dst_q;
            wb_result_q  <= (mem_op_q == OP_LW) ? i_mem_rd_data : mem_result_q;
            r_pc_wb      <= mem_npc_q;
        end
    end

    assign o_pc          = pc_q;
    assign o_mem_addr    = mem_result_q;
    assign o_mem_wr_data = mem_store_q;
    assign o_mem_wr_en   = mem_we_q;
endmodule

// File: tb/tb_risc16_pipe_core.sv
// Scoreboard bench: an ISA-level model predicts every retirement and store;
// a monitor compares them as the pipeline produces them.

module tb_risc16_pipe_core;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_inst, o_pc, i_mem_rd_data, o_mem_wr_data, o_mem_addr;
    logic        o_mem_wr_en;

    logic [15:0] imem    [0:65535];
    logic [15:0] dmem    [0:65535];
    logic [15:0] mdl_mem [0:65535];

    typedef struct packed { logic [15:0] npc; logic [127:0] regs; } ret_t;
    typedef struct packed { logic [15:0] addr; logic [15:0] data; } st_t;
    ret_t exp_q[$];
    st_t  st_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int ret_idx  = 0;
    int ret_cycle [0:63];

    risc16_pipe_core #(.p_RESET_PC(16'd0)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_inst        (i_inst),
        .o_pc          (o_pc),
        .i_mem_rd_data (i_mem_rd_data),
        .o_mem_wr_data (o_mem_wr_data),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wr_en   (o_mem_wr_en)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cycle <= cycle + 1;
    assign i_inst        = imem[o_pc];
    assign i_mem_rd_data = dmem[o_mem_addr];

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'd0, c};
    endfunction
    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction
    function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] a, input logic [9:0] imm);
        return {op, a, imm};
    endfunction

    function automatic logic [127:0] dut_regs();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = dut.regfile.r_memory[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural reference: one instruction per step, plain ISA semantics
    task automatic run_model(input int n);
        logic [15:0] r [0:7];
        logic [15:0] pc, inst, s7, nxt, ea, tgt;
        logic [2:0]  op, a, b, c;
        ret_t e;
        st_t  s;
        for (int k = 0; k < 8; k++) r[k] = 16'd0;
        pc = 16'd0;
        for (int k = 0; k < n; k++) begin
            inst = imem[pc];
            op = inst[15:13]; a = inst[12:10]; b = inst[9:7]; c = inst[2:0];
            s7  = {{9{inst[6]}}, inst[6:0]};
            nxt = pc + 16'd1;
            ea  = r[b] + s7;
            case (op)
                3'd0: r[a] = r[b] + r[c];
                3'd1: r[a] = r[b] + s7;
                3'd2: r[a] = ~(r[b] & r[c]);
                3'd3: r[a] = {inst[9:0], 6'd0};
                3'd4: begin mdl_mem[ea] = r[a]; s.addr = ea; s.data = r[a]; st_q.push_back(s); end
                3'd5: r[a] = mdl_mem[ea];
                3'd6: if (r[a] == r[b]) nxt = pc + 16'd1 + s7;
                default: begin tgt = r[b]; r[a] = pc + 16'd1; nxt = tgt; end
            endcase
            r[0] = 16'd0;
            e.npc = nxt;
            for (int j = 0; j < 8; j++) e.regs[j*16 +: 16] = r[j];
            exp_q.push_back(e);
            pc = nxt;
        end
    endtask

    task automatic mem_loop();
        forever begin
            @(posedge i_clk);
            if (o_mem_wr_en) dmem[o_mem_addr] = o_mem_wr_data;
        end
    endtask

    task automatic mon_loop();
        ret_t e;
        st_t  s;
        logic pend = 1'b0;
        logic [127:0] pend_regs = 128'd0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                pend = 1'b0;
                ret_idx = 0;
            end else begin
                if (pend) begin
                    chk("regs_after_retire", dut_regs(), pend_regs);
                    pend = 1'b0;
                end
                if (dut.r_valid_wb) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL retire_unexpected: got pc_wb %h expected no retirement", dut.r_pc_wb);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pc_wb", 128'(dut.r_pc_wb), 128'(e.npc));
                        pend_regs = e.regs;
                        pend = 1'b1;
                    end
                    if (ret_idx < 64) ret_cycle[ret_idx] = cycle;
                    ret_idx++;
                end
                if (o_mem_wr_en) begin
                    if (st_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL store_unexpected: got addr %h data %h expected no store", o_mem_addr, o_mem_wr_data);
                    end else begin
                        s = st_q.pop_front();
                        chk("store", 128'({o_mem_addr, o_mem_wr_data}), 128'({s.addr, s.data}));
                    end
                end
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_regs"}, dut_regs(), 128'd0);
        chk({tag, "_pc"}, 128'(o_pc), 128'd0);
        chk({tag, "_valid_wb"}, 128'(dut.r_valid_wb), 128'd0);
        chk({tag, "_mem_out"}, 128'({o_mem_wr_en, o_mem_addr, o_mem_wr_data}), 128'd0);
    endtask

    // Hold reset, load a program (0/1 directed, 2 random), build expectations, release
    task automatic start_prog(input int sel, input int n_model);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_q.delete();
        st_q.delete();
        for (int i = 0; i < 65536; i++) begin
            imem[i] = (sel == 2) ? 16'($urandom) : 16'd0;
            dmem[i] = (sel == 2) ? 16'($urandom) : 16'd0;
            mdl_mem[i] = dmem[i];
        end
        if (sel == 0) begin
            imem[0]  = ri (3'd3, 3'd1, 10'h3FF);
            imem[1]  = rri(3'd1, 3'd1, 3'd1, 7'd63);
            imem[2]  = rri(3'd1, 3'd2, 3'd0, 7'd5);
            imem[3]  = rrr(3'd0, 3'd3, 3'd2, 3'd2);
            imem[4]  = rri(3'd1, 3'd4, 3'd0, 7'd7);
            imem[5]  = rri(3'd4, 3'd4, 3'd0, 7'd3);
            imem[6]  = rri(3'd5, 3'd5, 3'd0, 7'd3);
            imem[7]  = rrr(3'd0, 3'd6, 3'd5, 3'd5);
            imem[8]  = rri(3'd1, 3'd0, 3'd0, 7'd1);
            imem[9]  = rri(3'd1, 3'd2, 3'd0, 7'd32);
            imem[10] = rri(3'd7, 3'd7, 3'd2, 7'd0);
            imem[11] = rri(3'd1, 3'd1, 3'd0, 7'd1);
            imem[12] = rri(3'd1, 3'd1, 3'd0, 7'd2);
            imem[32] = rri(3'd6, 3'd0, 3'd0, 7'h7F);
        end else if (sel == 1) begin
            for (int i = 0; i < 4; i++) imem[i] = rri(3'd1, 3'd1, 3'd0, 7'(i + 1));
            imem[4] = rri(3'd6, 3'd0, 3'd0, 7'h7F);
            imem[5] = rri(3'd1, 3'd2, 3'd0, 7'd9);
            imem[6] = rri(3'd1, 3'd2, 3'd0, 7'd10);
        end
        run_model(n_model);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
    endtask

    task automatic wait_retire(input int n, input int budget);
        int k = 0;
        while (ret_idx < n && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        #2;
        n_checks++;
        if (ret_idx < n) begin
            n_fail++;
            $display("FAIL retire_timeout: got %0d retirements expected %0d", ret_idx, n);
        end
    endtask

    initial begin
        fork
            mem_loop();
            mon_loop();
        join_none
        i_rst = 1'b1;
        #1 i_rst = 1'b0;
        #1 chk_reset("reset_init");

        // LUI/ADDI, forwarding, store/load with load-use stall, r0 write, JALR, BEQ loop
        start_prog(0, 40);
        wait_retire(14, 200);
        chk("r1_lui_addi",  128'(dut.regfile.r_memory[1]), 128'(16'hFFFF));
        chk("r3_fwd_add",   128'(dut.regfile.r_memory[3]), 128'(16'd10));
        chk("r5_load",      128'(dut.regfile.r_memory[5]), 128'(16'd7));
        chk("r6_load_use",  128'(dut.regfile.r_memory[6]), 128'(16'd14));
        chk("r7_jalr_link", 128'(dut.regfile.r_memory[7]), 128'(16'd11));
        chk("r2_after_r0",  128'(dut.regfile.r_memory[2]), 128'(16'd32));
        chk("r0_zero",      128'(dut.regfile.r_memory[0]), 128'd0);
        chk("mem3_store",   128'(dmem[3]), 128'(16'd7));
        chk("gap_fwd_no_stall", 128'(ret_cycle[3] - ret_cycle[2]), 128'd1);
        chk("gap_load_use",     128'(ret_cycle[7] - ret_cycle[6]), 128'd2);
        chk("gap_jalr_flush",   128'(ret_cycle[11] - ret_cycle[10]), 128'd3);
        chk("gap_beq_flush",    128'(ret_cycle[12] - ret_cycle[11]), 128'd3);
        wait_retire(20, 100);
        @(posedge i_clk); #3;
        i_rst = 1'b0;
        #1 chk_reset("reset_midrun");

        // Taken BEQ to itself at PC 4
        start_prog(1, 20);
        wait_retire(8, 100);
        chk("gap_beq_self", 128'(ret_cycle[5] - ret_cycle[4]), 128'd3);
        chk("r1_before_beq", 128'(dut.regfile.r_memory[1]), 128'(16'd4));
        chk("r2_flushed",    128'(dut.regfile.r_memory[2]), 128'd0);

        // Random programs against the ISA model
        for (int run = 0; run < 3; run++) begin
            start_prog(2, 408);
            wait_retire(400, 4000);
        end

        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
